// File: rtl/move_pkg.sv
// Shared definitions for the move collector slice.
// Move word layout flags and collector state encoding.
package move_pkg;

  localparam int MOVE_W_DEF = 48;

  localparam int F_INVALID   = 47;
  localparam int F_PROMOTE   = 46;
  localparam int F_PAWN      = 45;
  localparam int F_PAWN2     = 44;
  localparam int F_ENPASSANT = 43;
  localparam int F_CASTLE    = 42;
  localparam int F_CAPTURE   = 41;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/move_collector_if.sv
// Source-side read port and output stream of the collector.
// master = collector, slave = generators and consumer.
interface move_collector_if
  import move_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int MOVE_W  = MOVE_W_DEF
);

  logic [NUM_SRC-1:0]        src_done;
  logic [NUM_SRC-1:0]        src_empty;
  logic [NUM_SRC-1:0]        src_rden;
  logic [NUM_SRC*MOVE_W-1:0] src_data;
  logic                      out_valid;
  logic [MOVE_W-1:0]         out_data;
  logic                      out_ready;

  modport master (
    input  src_done, src_empty, src_data, out_ready,
    output src_rden, out_valid, out_data
  );

  modport slave (
    output src_done, src_empty, src_data, out_ready,
    input  src_rden, out_valid, out_data
  );

endinterface

// File: rtl/move_fifo.sv
// Synchronous show-ahead FIFO; rdata is the head entry.
// Caller guarantees no push when full and no pop when empty.
module move_fifo #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/move_collector.sv
// Drains NUM_SRC generator FIFOs into one output stream with
// fixed-priority or round-robin source selection.
module move_collector
  import move_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int MOVE_W  = MOVE_W_DEF,
  parameter int DEPTH   = 64,
  parameter int RR_MODE = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  move_collector_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] move_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(NUM_SRC);

  state_e             state;
  state_e             state_nx;
  logic [NUM_SRC-1:0] grabbed;
  logic [SW-1:0]      ptr;
  logic [SW-1:0]      last_served;
  logic [SW-1:0]      cand;
  logic               cand_ok;
  logic               all_grabbed;
  logic               pending;
  logic               rden;
  logic               drain_end;
  logic               restart;
  logic               push;
  logic               pop;
  logic [AW:0]        fifo_count;
  logic               fifo_empty;
  logic               fifo_full;

  // Later overwrites win, so the final index visited has top priority.
  function automatic logic [SW:0] pick(
    input logic [NUM_SRC-1:0] m,
    input logic [SW-1:0]      last
  );
    logic [SW:0] r;
    int          idx;
    r = '0;
    for (int j = NUM_SRC; j >= 1; j--) begin
      idx = (RR_MODE == 0) ? NUM_SRC - j
                           : (int'(last) + j) % NUM_SRC;
      if (m[idx]) r = {1'b1, SW'(idx)};
    end
    return r;
  endfunction

  assign {cand_ok, cand} = pick(bus.src_done & ~grabbed,
                                last_served);
  assign all_grabbed = &grabbed;
  assign restart     = start &&
                       (state == IDLE || state == DONE);

  assign rden = (state == DRAIN) && !bus.src_empty[ptr] &&
                ((int'(fifo_count) + int'(pending)) < DEPTH);
  assign drain_end = (state == DRAIN) &&
                     bus.src_empty[ptr] && !pending;

  assign push = pending && !fifo_full;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = SCAN;
      SCAN: begin
        if (all_grabbed)
          state_nx = DONE;
        else if (cand_ok && !bus.src_empty[cand])
          state_nx = DRAIN;
      end
      DRAIN: if (drain_end) state_nx = SCAN;
      DONE:  if (start) state_nx = SCAN;
    endcase
  end

  always_comb begin
    busy         = (state == SCAN) || (state == DRAIN);
    done         = (state == DONE) && fifo_empty;
    bus.src_rden = '0;
    if (rden) bus.src_rden[ptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grabbed     <= '0;
      ptr         <= '0;
      last_served <= SW'(NUM_SRC - 1);
      pending     <= 1'b0;
      move_count  <= '0;
    end else begin
      pending <= rden;
      if (restart) begin
        grabbed    <= '0;
        move_count <= '0;
      end else begin
        if (push && !(&move_count))
          move_count <= move_count + 1'b1;
        if (state == SCAN && cand_ok) begin
          if (bus.src_empty[cand]) grabbed[cand] <= 1'b1;
          else                     ptr           <= cand;
        end
        if (drain_end) begin
          grabbed[ptr] <= 1'b1;
          last_served  <= ptr;
        end
      end
    end
  end

  move_fifo #(
    .WIDTH (MOVE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (bus.src_data[int'(ptr)*MOVE_W +: MOVE_W]),
    .rdata   (bus.out_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign bus.out_valid = !fifo_empty;

endmodule

// File: tb/tb_move_collector.sv
// Bench for move_collector: fixed-priority instance (DEPTH 4, CNT_W 4)
// and round-robin instance (DEPTH 64, CNT_W 8) against a queue model.
module tb_move_collector;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_s [2];
  logic         ready_s [2];
  logic [7:0]   sdone   [2];
  logic [7:0]   sempty  [2];
  logic [383:0] sdata   [2];
  logic [7:0]   rden_o  [2];
  logic         ov      [2];
  logic [47:0]  od      [2];
  logic         busy_o  [2];
  logic         done_o  [2];
  logic [7:0]   mc      [2];
  logic [3:0]   mc0;

  logic [47:0] srcq  [2][8][$];
  int          nreads[2][8];
  logic        proto_bad [2];
  logic [47:0] got   [2][$];
  logic [47:0] ref_q [8][$];
  logic [47:0] exp_q [$];
  int          lastm = 0;
  int          checks = 0;
  int          errors = 0;

  move_collector_if #(.NUM_SRC(8), .MOVE_W(48)) bus0 ();
  move_collector_if #(.NUM_SRC(8), .MOVE_W(48)) bus1 ();

  assign bus0.src_done  = sdone[0];
  assign bus0.src_empty = sempty[0];
  assign bus0.src_data  = sdata[0];
  assign bus0.out_ready = ready_s[0];
  assign rden_o[0]      = bus0.src_rden;
  assign ov[0]          = bus0.out_valid;
  assign od[0]          = bus0.out_data;
  assign mc[0]          = {4'b0, mc0};

  assign bus1.src_done  = sdone[1];
  assign bus1.src_empty = sempty[1];
  assign bus1.src_data  = sdata[1];
  assign bus1.out_ready = ready_s[1];
  assign rden_o[1]      = bus1.src_rden;
  assign ov[1]          = bus1.out_valid;
  assign od[1]          = bus1.out_data;

  move_collector #(
    .NUM_SRC(8), .MOVE_W(48), .DEPTH(4),
    .RR_MODE(0), .CNT_W(4)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]),
    .bus(bus0.master), .busy(busy_o[0]), .done(done_o[0]),
    .move_count(mc0)
  );

  move_collector #(
    .NUM_SRC(8), .MOVE_W(48), .DEPTH(64),
    .RR_MODE(1), .CNT_W(8)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]),
    .bus(bus1.master), .busy(busy_o[1]), .done(done_o[1]),
    .move_count(mc[1])
  );

  // Source FIFO model: registered read data, empty after pop.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if ($countones(rden_o[k]) > 1) proto_bad[k] <= 1'b1;
      if ((rden_o[k] & ~sdone[k]) != 8'h00)
        proto_bad[k] <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (rden_o[k][i]) begin
          nreads[k][i] <= nreads[k][i] + 1;
          if (srcq[k][i].size() == 0)
            proto_bad[k] <= 1'b1;
          else
            sdata[k][i*48 +: 48] <= srcq[k][i].pop_front();
        end
        sempty[k][i] <= (srcq[k][i].size() == 0);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      if (ready_s[k] && ov[k]) got[k].push_back(od[k]);
  end

  function automatic logic [47:0] rword();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[47:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input int i, input int n);
    logic [47:0] w;
    for (int j = 0; j < n; j++) begin
      w = rword();
      srcq[k][i].push_back(w);
      ref_q[i].push_back(w);
    end
  endtask

  // Appends moves in service order: descending index for instance 0,
  // cyclic after the last drained source for instance 1.
  task automatic build_exp(input int k, input logic [7:0] m);
    int i;
    int nl;
    nl = lastm;
    for (int j = 0; j < 8; j++) begin
      i = (k == 0) ? 7 - j : (lastm + 1 + j) % 8;
      if (m[i] && ref_q[i].size() > 0) begin
        nl = i;
        while (ref_q[i].size() > 0)
          exp_q.push_back(ref_q[i].pop_front());
      end
    end
    if (k == 1) lastm = nl;
  endtask

  task automatic pulse_start(input int k);
    got[k].delete();
    start_s[k] = 1'b1;
    step();
    start_s[k] = 1'b0;
  endtask

  task automatic drain(input int k, input int n, input int pct,
                       input bit need_done, output bit to);
    to = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (got[k].size() >= n && (!need_done || done_o[k])) begin
        to = 1'b0;
        return;
      end
      ready_s[k] = ($urandom_range(99) < pct);
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({ov[k], busy_o[k], done_o[k]} !== 3'b000 ||
          mc[k] !== 8'd0 || rden_o[k] !== 8'd0) begin
        errors++;
        $display("FAIL reset[%0d]: v/b/d=%b%b%b cnt=%0d rden=%h want 0",
                 k, ov[k], busy_o[k], done_o[k], mc[k], rden_o[k]);
      end
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_priority();
    bit to;
    int c;
    exp_q.delete();
    load(0, 7, 3);
    load(0, 2, 1);
    build_exp(0, 8'hFF);
    sdone[0] = 8'hFF;
    ready_s[0] = 1'b1;
    step();
    pulse_start(0);
    c = 0;
    while (rden_o[0] == 8'h00 && c < 20) begin
      step();
      c++;
    end
    step();
    checks++;
    if (ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL latency1: out_valid=%b want 0", ov[0]);
    end
    step();
    checks++;
    if (ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL latency2: out_valid=%b want 1", ov[0]);
    end
    drain(0, 4, 100, 1'b1, to);
    checks++;
    if (to || got[0].size() != 4) begin
      errors++;
      $display("FAIL prio_len: got %0d moves want 4 (timeout=%0d)",
               got[0].size(), to);
    end
    for (int i = 0; i < 4 && i < got[0].size(); i++) begin
      checks++;
      if (got[0][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL prio_data[%0d]: got %h want %h",
                 i, got[0][i], exp_q[i]);
      end
    end
    checks++;
    if (mc[0] !== 8'd4 || done_o[0] !== 1'b1 || ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL prio_end: cnt=%0d done=%b valid=%b want 4/1/0",
               mc[0], done_o[0], ov[0]);
    end
  endtask

  task automatic test_round_robin();
    bit to;
    exp_q.delete();
    load(1, 3, 1);
    build_exp(1, 8'h08);
    sdone[1] = 8'h08;
    ready_s[1] = 1'b1;
    step();
    pulse_start(1);
    drain(1, 1, 100, 1'b0, to);
    repeat (5) step();
    load(1, 1, 1);
    load(1, 5, 1);
    load(1, 6, 1);
    build_exp(1, 8'h62);
    step();
    sdone[1] = 8'hFF;
    drain(1, 4, 100, 1'b1, to);
    checks++;
    if (to || got[1].size() != 4) begin
      errors++;
      $display("FAIL rr_len: got %0d moves want 4 (timeout=%0d)",
               got[1].size(), to);
    end
    for (int i = 0; i < 4 && i < got[1].size(); i++) begin
      checks++;
      if (got[1][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %h want %h",
                 i, got[1][i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int r;
    int base;
    r = $urandom_range(7);
    exp_q.delete();
    load(0, r, 10);
    build_exp(0, 8'hFF);
    base = nreads[0][r];
    sdone[0] = 8'hFF;
    ready_s[0] = 1'b0;
    step();
    pulse_start(0);
    repeat (30) step();
    checks++;
    if (ov[0] !== 1'b1 || nreads[0][r] - base != 4 ||
        rden_o[0] !== 8'h00 || mc[0] !== 8'd4) begin
      errors++;
      $display("FAIL full_stall: valid=%b reads=%0d rden=%h cnt=%0d want 1/4/00/4",
               ov[0], nreads[0][r] - base, rden_o[0], mc[0]);
    end
    drain(0, 10, 100, 1'b1, to);
    checks++;
    if (to || got[0].size() != 10) begin
      errors++;
      $display("FAIL full_len: got %0d moves want 10 (timeout=%0d)",
               got[0].size(), to);
    end
    for (int i = 0; i < 10 && i < got[0].size(); i++) begin
      checks++;
      if (got[0][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_data[%0d]: got %h want %h",
                 i, got[0][i], exp_q[i]);
      end
    end
  endtask

  task automatic test_all_empty();
    int c;
    for (int k = 0; k < 2; k++) begin
      sdone[k] = 8'hFF;
      ready_s[k] = 1'b1;
      pulse_start(k);
      c = 0;
      while (!done_o[k] && c < 40) begin
        step();
        c++;
      end
      checks++;
      if (c > 9 || mc[k] !== 8'd0 || ov[k] !== 1'b0) begin
        errors++;
        $display("FAIL all_empty[%0d]: cycles=%0d cnt=%0d valid=%b want <=9/0/0",
                 k, c, mc[k], ov[k]);
      end
    end
  endtask

  task automatic test_saturate();
    bit to;
    exp_q.delete();
    for (int n = 0; n < 20; n++) load(0, $urandom_range(7), 1);
    build_exp(0, 8'hFF);
    sdone[0] = 8'hFF;
    step();
    pulse_start(0);
    drain(0, 20, 80, 1'b1, to);
    checks++;
    if (to || got[0].size() != 20 || mc[0] !== 8'd15) begin
      errors++;
      $display("FAIL saturate: got %0d moves cnt=%0d want 20/15 (timeout=%0d)",
               got[0].size(), mc[0], to);
    end
    for (int i = 0; i < 20 && i < got[0].size(); i++) begin
      checks++;
      if (got[0][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sat_data[%0d]: got %h want %h",
                 i, got[0][i], exp_q[i]);
      end
    end
  endtask

  // Random loads per source; one source is held back (not done),
  // must stay unread, then is served once it reports done.
  task automatic test_random();
    bit to;
    int k;
    int h;
    int n1;
    int hb;
    int cmax;
    logic [7:0] m;
    for (int it = 0; it < 8; it++) begin
      k = it % 2;
      cmax = (k == 0) ? 15 : 255;
      exp_q.delete();
      for (int i = 0; i < 8; i++) load(k, i, $urandom_range(4));
      h = $urandom_range(7);
      m = 8'hFF;
      m[h] = 1'b0;
      build_exp(k, m);
      n1 = exp_q.size();
      hb = nreads[k][h];
      sdone[k] = m;
      step();
      pulse_start(k);
      drain(k, n1, 70, 1'b0, to);
      repeat (20) begin
        ready_s[k] = $urandom_range(1);
        step();
      end
      checks++;
      if (to || nreads[k][h] != hb || busy_o[k] !== 1'b1) begin
        errors++;
        $display("FAIL held[%0d]: reads=%0d busy=%b want 0/1 (timeout=%0d)",
                 it, nreads[k][h] - hb, busy_o[k], to);
      end
      build_exp(k, 8'h01 << h);
      sdone[k] = 8'hFF;
      drain(k, exp_q.size(), 70, 1'b1, to);
      checks++;
      if (to || got[k].size() != exp_q.size() ||
          int'(mc[k]) != ((exp_q.size() > cmax) ? cmax : exp_q.size())) begin
        errors++;
        $display("FAIL rand_end[%0d]: got %0d moves cnt=%0d want %0d (timeout=%0d)",
                 it, got[k].size(), mc[k], exp_q.size(), to);
      end
      for (int i = 0; i < exp_q.size() && i < got[k].size(); i++) begin
        checks++;
        if (got[k][i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_data[%0d.%0d]: got %h want %h",
                   it, i, got[k][i], exp_q[i]);
          break;
        end
      end
      for (int q = 0; q < 2; q++) begin
        checks++;
        if (proto_bad[q] !== 1'b0) begin
          errors++;
          $display("FAIL src_protocol[%0d]: bad read seen=%b want 0",
                   q, proto_bad[q]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    load(1, $urandom_range(7), 8);
    sdone[1] = 8'hFF;
    ready_s[1] = 1'b0;
    step();
    pulse_start(1);
    c = 0;
    while (mc[1] < 8'd2 && c < 40) begin
      step();
      c++;
    end
    reset_n = 1'b0;
    step();
    checks++;
    if (ov[1] !== 1'b0 || mc[1] !== 8'd0 || rden_o[1] !== 8'h00 ||
        busy_o[1] !== 1'b0 || c >= 40) begin
      errors++;
      $display("FAIL reset_mid: valid=%b cnt=%0d rden=%h busy=%b want 0 (wait=%0d)",
               ov[1], mc[1], rden_o[1], busy_o[1], c);
    end
    for (int i = 0; i < 8; i++) begin
      srcq[1][i].delete();
      ref_q[i].delete();
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0;
      ready_s[k] = 1'b0;
      sdone[k]   = 8'h00;
      proto_bad[k] = 1'b0;
    end
    test_reset();
    test_priority();
    test_round_robin();
    test_backpressure();
    test_all_empty();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
